mips_simple_cpu: RTL and testbench



---
 rtl/mips_pkg.sv | 54 +++++
 rtl/mips_alu.sv | 24 ++
 rtl/mips_simple_cpu.sv | 126 ++++++++++++
 tb/tb_mips_simple_cpu.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, ALU op enum and the fixed ROM programs
// shared by the MIPS subset core.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    // alt selects a tiny program that tries to write $0 and then copies $0+$0 into $2.
    function automatic logic [31:0] prog_word(input int unsigned idx, input logic alt);
        logic [31:0] w;
        w = 32'h0000_0000;
        if (alt) begin
            case (idx)
                0: w = 32'h2000_0007;
                1: w = 32'h0000_1020;
                2: w = 32'h1000_FFFF;
                default: w = 32'h0000_0000;
            endcase
        end else begin
            case (idx)
                0: w = 32'h2001_0005;
                1: w = 32'h2002_0000;
                2: w = 32'h0041_1020;
                3: w = 32'h2021_FFFF;
                4: w = 32'h1420_FFFD;
                5: w = 32'hAC02_0000;
                6: w = 32'h8C03_0000;
                7: w = 32'h1000_FFFF;
                default: w = 32'h0000_0000;
            endcase
        end
        return w;
    endfunction

endpackage

// File: rtl/mips_alu.sv
// mips_alu: combinational 32-bit ALU with zero flag for the MIPS subset core.
module mips_alu
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] y,
    output logic        zero
);

    logic [31:0] diff;

    always_comb begin
        diff = a - b;
        y    = op == ALU_ADD ? a + b :
               op == ALU_SUB ? diff :
               op == ALU_AND ? a & b :
               op == ALU_OR  ? a | b :
               op == ALU_SLT ? {31'b0, $signed(a) < $signed(b)} : 32'h0;
        zero = y == 32'h0;
    end

endmodule

// File: rtl/mips_simple_cpu.sv
// mips_simple_cpu: single-cycle MIPS subset core with fixed instruction ROM,
// small data RAM and register $2 exposed on out.
module mips_simple_cpu
    import mips_pkg::*;
#(
    parameter int   IMEM_WORDS = 64,
    parameter int   DMEM_WORDS = 64,
    parameter logic ALT_PROG   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] out
);

    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_WORDS);

    logic [31:0]                  pc_q, pc_d, pc_plus4, br_tgt, j_tgt;
    logic [31:0][31:0]            regs_q, regs_d;
    logic [DMEM_WORDS-1:0][31:0]  dmem_q, dmem_d;
    logic [31:0]                  instr, imm_sext, rd1, rd2, alu_b, alu_y, wdata, mem_rdata;
    logic [5:0]                   opcode, funct;
    logic [4:0]                   rs, rt, rd, dst;
    logic                         reg_we, mem_we, mem_to_reg, use_imm, fn_ok, alu_zero;
    alu_op_e                      alu_op, fn_op;
    logic                         unused_bits;

    always_comb begin
        instr     = prog_word(32'(pc_q[IW+1:2]), ALT_PROG);
        opcode    = instr[31:26];
        rs        = instr[25:21];
        rt        = instr[20:16];
        rd        = instr[15:11];
        funct     = instr[5:0];
        imm_sext  = {{16{instr[15]}}, instr[15:0]};
        pc_plus4  = pc_q + 32'd4;
        br_tgt    = pc_plus4 + {imm_sext[29:0], 2'b00};
        j_tgt     = {pc_plus4[31:28], instr[25:0], 2'b00};
        rd1       = rs == 5'd0 ? 32'h0 : regs_q[rs];
        rd2       = rt == 5'd0 ? 32'h0 : regs_q[rt];
        mem_rdata = dmem_q[alu_y[DW+1:2]];
    end

    always_comb begin
        fn_ok = funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                funct == FN_OR  || funct == FN_SLT;
        fn_op = funct == FN_SUB ? ALU_SUB :
                funct == FN_AND ? ALU_AND :
                funct == FN_OR  ? ALU_OR  :
                funct == FN_SLT ? ALU_SLT : ALU_ADD;
    end

    // Anything not matched below falls through as a NOP.
    always_comb begin
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        mem_to_reg = 1'b0;
        use_imm    = 1'b0;
        dst        = rd;
        alu_op     = ALU_ADD;
        pc_d       = pc_plus4;
        case (opcode)
            OP_RTYPE: begin
                alu_op = fn_op;
                reg_we = fn_ok;
            end
            OP_ADDI: begin
                use_imm = 1'b1;
                reg_we  = 1'b1;
                dst     = rt;
            end
            OP_LW: begin
                use_imm    = 1'b1;
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                dst        = rt;
            end
            OP_SW: begin
                use_imm = 1'b1;
                mem_we  = 1'b1;
            end
            OP_BEQ: begin
                alu_op = ALU_SUB;
                pc_d   = alu_zero ? br_tgt : pc_plus4;
            end
            OP_BNE: begin
                alu_op = ALU_SUB;
                pc_d   = alu_zero ? pc_plus4 : br_tgt;
            end
            OP_J: pc_d = j_tgt;
            default: ;
        endcase
    end

    mips_alu u_alu (
        .a    (rd1),
        .b    (alu_b),
        .op   (alu_op),
        .y    (alu_y),
        .zero (alu_zero)
    );

    always_comb begin
        alu_b  = use_imm ? imm_sext : rd2;
        wdata  = mem_to_reg ? mem_rdata : alu_y;
        regs_d = regs_q;
        if (reg_we && dst != 5'd0 && !reset)
            regs_d[dst] = wdata;
        dmem_d = dmem_q;
        if (mem_we && !reset)
            dmem_d[alu_y[DW+1:2]] = rd2;
    end

    always_ff @(posedge clk) begin
        pc_q   <= reset ? 32'h0 : pc_d;
        regs_q <= reset ? '0 : regs_d;
    end

    // Data RAM keeps its contents across reset.
    always_ff @(posedge clk)
        dmem_q <= dmem_d;

    assign out         = regs_q[2];
    assign unused_bits = ^instr[10:6];

endmodule

// File: tb/tb_mips_simple_cpu.sv
// tb_mips_simple_cpu: scoreboard bench checking reset, the summation program
// timeline, memory path, mid-run reset and $0 write protection.
module tb_mips_simple_cpu;

    logic        clk;
    logic        reset;
    logic        reset_alt;
    logic [31:0] out;
    logic [31:0] out_alt;
    logic [31:0] exp_q[$];
    int          tests;
    int          fails;

    mips_simple_cpu dut (
        .clk   (clk),
        .reset (reset),
        .out   (out)
    );

    mips_simple_cpu #(.ALT_PROG(1'b1)) dut_alt (
        .clk   (clk),
        .reset (reset_alt),
        .out   (out_alt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_out(input int k);
        return k < 3 ? 32'd0 : k < 6 ? 32'd5 : k < 9 ? 32'd9 :
               k < 12 ? 32'd12 : k < 15 ? 32'd14 : 32'd15;
    endfunction

    function automatic logic [31:0] exp_pc(input int k);
        if (k == 1) return 32'h4;
        if (k == 2) return 32'h8;
        if (k <= 16) return (k - 3) % 3 == 0 ? 32'hC : (k - 3) % 3 == 1 ? 32'h10 : 32'h8;
        if (k == 17) return 32'h14;
        if (k == 18) return 32'h18;
        return 32'h1C;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        reset_alt = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (out !== 32'd0) begin
                fails++;
                $display("FAIL reset_out edge %0d: got %0d expected 0", i, out);
            end
            tests++;
            if (dut.pc_q !== 32'h0) begin
                fails++;
                $display("FAIL reset_pc edge %0d: got 0x%0h expected 0x0", i, dut.pc_q);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_program;
        logic [31:0] e;
        logic [31:0] prev_pc;
        int          taken;
        int          fell;
        taken   = 0;
        fell    = 0;
        prev_pc = 32'h0;
        for (int k = 1; k <= 25; k++) begin
            exp_q.push_back(exp_out(k));
            tick();
            e = exp_q.pop_front();
            tests++;
            if (out !== e) begin
                fails++;
                $display("FAIL prog_out edge %0d: got %0d expected %0d", k, out, e);
            end
            tests++;
            if (dut.pc_q !== exp_pc(k)) begin
                fails++;
                $display("FAIL prog_pc edge %0d: got 0x%0h expected 0x%0h", k, dut.pc_q, exp_pc(k));
            end
            if (prev_pc == 32'h10 && dut.pc_q == 32'h8) taken++;
            if (prev_pc == 32'h10 && dut.pc_q == 32'h14) fell++;
            prev_pc = dut.pc_q;
            if (k == 1) begin
                tests++;
                if (dut.regs_q[1] !== 32'd5) begin
                    fails++;
                    $display("FAIL first_r1: got %0d expected 5", dut.regs_q[1]);
                end
            end
            if (k == 19) begin
                tests++;
                if (dut.dmem_q[0] !== 32'd15) begin
                    fails++;
                    $display("FAIL dmem0: got %0d expected 15", dut.dmem_q[0]);
                end
                tests++;
                if (dut.regs_q[3] !== 32'd15) begin
                    fails++;
                    $display("FAIL r3_load: got %0d expected 15", dut.regs_q[3]);
                end
                tests++;
                if (dut.regs_q[1] !== 32'd0) begin
                    fails++;
                    $display("FAIL r1_final: got %0d expected 0", dut.regs_q[1]);
                end
            end
        end
        tests++;
        if (taken != 4) begin
            fails++;
            $display("FAIL bne_taken: got %0d expected 4", taken);
        end
        tests++;
        if (fell != 1) begin
            fails++;
            $display("FAIL bne_fallthrough: got %0d expected 1", fell);
        end
    endtask

    task automatic test_hold;
        logic [31:0] e;
        for (int k = 0; k < 40; k++) begin
            exp_q.push_back(32'd15);
            tick();
            e = exp_q.pop_front();
            tests++;
            if (out !== e || dut.pc_q !== 32'h1C) begin
                fails++;
                $display("FAIL hold edge %0d: got out=%0d pc=0x%0h expected out=%0d pc=0x1c",
                         k, out, dut.pc_q, e);
            end
        end
    endtask

    task automatic test_mid_reset;
        logic [31:0] e;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (8) tick();
        tests++;
        if (out !== 32'd9) begin
            fails++;
            $display("FAIL mid_pre edge 8: got %0d expected 9", out);
        end
        reset = 1'b1;
        tick();
        tests++;
        if (out !== 32'd0 || dut.pc_q !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset: got out=%0d pc=0x%0h expected out=0 pc=0x0", out, dut.pc_q);
        end
        reset = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            exp_q.push_back(exp_out(k));
            tick();
            e = exp_q.pop_front();
            tests++;
            if (out !== e) begin
                fails++;
                $display("FAIL rerun_out edge %0d: got %0d expected %0d", k, out, e);
            end
        end
    endtask

    task automatic test_zero_reg;
        reset_alt = 1'b0;
        repeat (5) tick();
        tests++;
        if (out_alt !== 32'd0) begin
            fails++;
            $display("FAIL zero_reg_out: got %0d expected 0", out_alt);
        end
        tests++;
        if (dut_alt.pc_q !== 32'h8) begin
            fails++;
            $display("FAIL zero_reg_pc: got 0x%0h expected 0x8", dut_alt.pc_q);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        reset_alt = 1'b1;
        test_reset();
        test_program();
        test_hold();
        test_mid_reset();
        test_zero_reg();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
